// File: rtl/bsg_downstream_pkg.sv
// Shared definitions for the downstream link receiver: beat indexing and the
// byte-lane map that places channel bytes into the assembled core word.
package bsg_downstream_pkg;

  localparam int BEATS_PER_WORD = 4;
  localparam int LANE_W         = 8;

  typedef logic [1:0] beat_t;

  // Beat index bit 1 selects the upper half-word, bit 0 the odd byte; ch1 sits two bytes above ch0.
  function automatic logic [2:0] lane_idx(input beat_t beat, input logic ch);
    return {beat[1], ch, beat[0]};
  endfunction

  function automatic logic [8*LANE_W-1:0] lane_place(input beat_t beat,
                                                     input logic [LANE_W-1:0] ch0,
                                                     input logic [LANE_W-1:0] ch1);
    logic [8*LANE_W-1:0] w;
    w = '0;
    w[int'(lane_idx(beat, 1'b0))*LANE_W +: LANE_W] = ch0;
    w[int'(lane_idx(beat, 1'b1))*LANE_W +: LANE_W] = ch1;
    return w;
  endfunction

endpackage

// File: rtl/bsg_downstream_fifo.sv
// Small word FIFO with wrap-bit pointers; head reads straight from storage and
// is forced to zero while empty. A push while full is accepted only alongside a pop.
module bsg_downstream_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bsg_downstream_in.sv
// Receive endpoint of the off-chip link: collects four two-channel beats into a
// core word, buffers it, and returns credit tokens as the core consumes words.
module bsg_downstream_in
  import bsg_downstream_pkg::*;
#(
  parameter int CH_W        = 8,
  parameter int WORD_W      = 4*2*CH_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int TOKEN_DECIM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_valid_in,
  input  logic [CH_W-1:0]   io_data_in_ch0,
  input  logic [CH_W-1:0]   io_data_in_ch1,
  output logic              io_token_out,
  output logic [WORD_W-1:0] core_data_out,
  output logic              core_valid_out,
  input  logic              core_yumi_in,
  output logic              overflow_out
);

  localparam int TOK_W  = $clog2(TOKEN_DECIM) + 1;
  localparam int PAIR_W = 2*CH_W;
  localparam int ASM_W  = (BEATS_PER_WORD-1)*PAIR_W;

  beat_t                          r_beat;
  logic [ASM_W-1:0]               r_asm;
  logic [BEATS_PER_WORD*PAIR_W-1:0] w_beats;
  logic [WORD_W-1:0]              w_word;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_full;
  logic                           w_empty;
  logic [TOK_W-1:0]               r_tok_cnt;
  logic                           r_tok;
  logic                           r_ovf;

  assign w_push = io_valid_in && (r_beat == beat_t'(BEATS_PER_WORD-1));
  assign w_pop  = core_yumi_in && !w_empty;

  // Beat capture: beats 0-2 shift in from the top so beat 0 ends up lowest.
  always_ff @(posedge clk) begin
    if (rst)              r_beat <= '0;
    else if (io_valid_in) r_beat <= r_beat + beat_t'(1);
  end

  always_ff @(posedge clk) begin
    if (io_valid_in && !w_push)
      r_asm <= {io_data_in_ch1, io_data_in_ch0, r_asm[ASM_W-1:PAIR_W]};
  end

  // Word formation: the final beat comes straight from the pins.
  assign w_beats = {io_data_in_ch1, io_data_in_ch0, r_asm};

  always_comb begin
    w_word = '0;
    for (int b = 0; b < BEATS_PER_WORD; b++) begin
      w_word[int'(lane_idx(beat_t'(b), 1'b0))*CH_W +: CH_W] = w_beats[b*PAIR_W +: CH_W];
      w_word[int'(lane_idx(beat_t'(b), 1'b1))*CH_W +: CH_W] = w_beats[b*PAIR_W+CH_W +: CH_W];
    end
  end

  bsg_downstream_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_head  (core_data_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Credit return and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tok_cnt <= '0;
      r_tok     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_tok <= 1'b0;
      if (w_pop) begin
        if (r_tok_cnt == TOK_W'(TOKEN_DECIM-1)) begin
          r_tok_cnt <= '0;
          r_tok     <= 1'b1;
        end else begin
          r_tok_cnt <= r_tok_cnt + TOK_W'(1);
        end
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign core_valid_out = !w_empty;
  assign io_token_out   = r_tok;
  assign overflow_out   = r_ovf;

endmodule
